// File: rtl/b2r_ctrl_pkg.sv
// Shared types and size helpers for the block-to-row converter sequencer.
package b2r_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int elem_per_input(input int chunk_size, input int num_cores);
        return chunk_size * num_cores;
    endfunction

    function automatic int in_width(input int width, input int chunk_size, input int num_cores);
        return width * elem_per_input(chunk_size, num_cores);
    endfunction

    function automatic int num_beats(input int row, input int col,
                                     input int chunk_size, input int num_cores);
        return (row * col) / elem_per_input(chunk_size, num_cores);
    endfunction

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/b2r_beat_pacer.sv
// Beat pacer: enforces BEAT_GAP idle cycles between accepted beats and
// registers each accepted chunk as a one-cycle strobe to the converter.
module b2r_beat_pacer
    import b2r_ctrl_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int BEAT_GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              gap_zero_o,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int               GAP_W = cnt_w(BEAT_GAP);
    localparam logic [GAP_W-1:0] GAP_L = GAP_W'(BEAT_GAP);

    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              vld_q;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        gap_d = gap_q;
        if (accept_i) begin
            gap_d = GAP_L;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            gap_q <= gap_d;
            vld_q <= accept_i;
            if (accept_i) begin
                data_q <= data_i;
            end
        end
    end

    assign gap_zero_o = (gap_q == '0);
    assign vld_o      = vld_q;
    assign data_o     = data_q;

endmodule

// File: rtl/b2r_ctrl.sv
// Sequencer for the block-to-row converter: paces MAC chunks in, counts rows out.
// Optional drain watchdog enabled by defining B2R_CTRL_TIMEOUT_EN.
module b2r_ctrl
    import b2r_ctrl_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int ROW            = 8,
    parameter int COL            = 6,
    parameter int CHUNK_SIZE     = 4,
    parameter int NUM_CORES      = 2,
    parameter int BEAT_GAP       = 1,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IN_W  = in_width(WIDTH, CHUNK_SIZE, NUM_CORES),
    localparam int IDX_W = (ROW > 1) ? $clog2(ROW) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             conv_en,
    output logic             conv_in_valid,
    output logic [IN_W-1:0]  conv_in_data,
    input  logic             conv_output_ready,
    input  logic             conv_buffer_done,
    output logic             row_valid,
    output logic [IDX_W-1:0] row_idx,
    output logic             overrun,
    output logic             timeout
);

    localparam int NB     = num_beats(ROW, COL, CHUNK_SIZE, NUM_CORES);
    localparam int BEAT_W = cnt_w(NB);
    localparam int ROW_W  = cnt_w(ROW);

    localparam logic [BEAT_W-1:0] NB_L     = BEAT_W'(NB);
    localparam logic [BEAT_W-1:0] NB_LAST  = BEAT_W'(NB - 1);
    localparam logic [ROW_W-1:0]  ROW_L    = ROW_W'(ROW);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROW - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(ROW - 1);

    if ((ROW * COL) % (CHUNK_SIZE * NUM_CORES) != 0) begin : g_bad_geometry
        $error("b2r_ctrl: ROW*COL must be a multiple of CHUNK_SIZE*NUM_CORES");
    end

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic              overrun_q, overrun_d;
    logic              in_run, accept, row_strobe, gap_zero, wd_fire;
    logic              buf_done_unused;

    // The converter's drain flag is observed only; sequencing relies on row strobes.
    assign buf_done_unused = conv_buffer_done;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        row_cnt_d  = row_cnt_q;
        overrun_d  = overrun_q;
        in_run     = (state_q == LOAD) || (state_q == DRAIN);
        s_ready    = (state_q == LOAD) && gap_zero && (beat_cnt_q < NB_L);
        accept     = s_valid && s_ready;
        row_strobe = in_run && conv_output_ready;

        if (accept) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
        // Strobes past the last row, or outside a matrix, are flagged, never counted.
        if (row_strobe && (row_cnt_q < ROW_L)) begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
        end else if (conv_output_ready) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    beat_cnt_d = '0;
                    row_cnt_d  = '0;
                    overrun_d  = 1'b0;
                end
            end
            LOAD: begin
                if (accept && (beat_cnt_q == NB_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((row_strobe && (row_cnt_q == ROW_LAST)) || (row_cnt_q == ROW_L) || wd_fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef B2R_CTRL_TIMEOUT_EN
    localparam int              WD_W    = cnt_w(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d;

    // Counts idle DRAIN cycles since the last row strobe.
    always_comb begin
        wdog_d    = wdog_q;
        wd_fire   = 1'b0;
        timeout_d = timeout_q;
        if ((state_q != DRAIN) || row_strobe) begin
            wdog_d = '0;
        end else if (wdog_q == WD_LAST) begin
            wd_fire = 1'b1;
        end else begin
            wdog_d = wdog_q + WD_W'(1);
        end
        if ((state_q == IDLE) && start) begin
            timeout_d = 1'b0;
        end else if (wd_fire) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    localparam int unused_wd_limit = TIMEOUT_CYCLES;

    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    b2r_beat_pacer #(
        .DATA_W  (IN_W),
        .BEAT_GAP(BEAT_GAP)
    ) u_pacer (
        .clk       (clk),
        .rst       (rst),
        .accept_i  (accept),
        .data_i    (s_data),
        .gap_zero_o(gap_zero),
        .vld_o     (conv_in_valid),
        .data_o    (conv_in_data)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign conv_en   = in_run;
    assign row_valid = row_strobe;
    assign row_idx   = (row_cnt_q >= ROW_L) ? IDX_MAX : row_cnt_q[IDX_W-1:0];
    assign overrun   = overrun_q;

endmodule
